// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: shows LFSR mole patterns, scores key hits.
// Ports: CLK, RESET (async high), START, keypad[7:0] -> mole, score, rounds_left, busy, game_over.
module mole_round_ctrl #(
    parameter int TICK_DIV    = 50000,
    parameter int SHOW_TICKS  = 8,
    parameter int GAP_TICKS   = 4,
    parameter int GAME_ROUNDS = 100
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] keypad,
    output logic [7:0] mole,
    output logic [7:0] score,
    output logic [7:0] rounds_left,
    output logic       busy,
    output logic       game_over
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SHOW = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int DW   = $clog2(TICK_DIV);
    localparam int TMAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [7:0]    SEED      = 8'hA5;

    // Fibonacci LFSR, taps 8,6,5,4; a nonzero state never maps to zero.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    logic [1:0]    state;
    logic [7:0]    lfsr;
    logic [7:0]    kp_q;
    logic [DW-1:0] div;
    logic [TW-1:0] tcnt;

    logic       tick;
    logic [7:0] hit;
    logic [3:0] hcnt;
    logic [8:0] sum;
    logic [7:0] score_sat;
    logic       show_end;
    logic       gap_end;

    assign busy      = (state == SHOW) || (state == GAP);
    assign game_over = (state == DONE);
    assign tick      = busy && (div == DIV_LAST);

    assign hit       = keypad & ~kp_q & mole;
    assign hcnt      = 4'($countones(hit));
    assign sum       = {1'b0, score} + {5'd0, hcnt};
    assign score_sat = sum[8] ? 8'hFF : sum[7:0];

    // A cleared pattern (all moles hit last cycle) ends the round early.
    assign show_end  = (mole == 8'h00) || (tick && (tcnt == SHOW_LAST));
    assign gap_end   = tick && (tcnt == GAP_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            mole        <= 8'h00;
            score       <= 8'h00;
            rounds_left <= 8'h00;
            lfsr        <= SEED;
            kp_q        <= 8'h00;
            div         <= '0;
            tcnt        <= '0;
        end else begin
            kp_q <= keypad;
            if (tick) begin
                div  <= '0;
                tcnt <= tcnt + 1'b1;
            end else if (busy) begin
                div <= div + 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        state       <= SHOW;
                        mole        <= SEED;
                        lfsr        <= lfsr_step(SEED);
                        score       <= 8'h00;
                        rounds_left <= 8'(GAME_ROUNDS);
                        div         <= '0;
                        tcnt        <= '0;
                    end
                end
                SHOW: begin
                    score <= score_sat;
                    if (show_end) begin
                        state       <= GAP;
                        mole        <= 8'h00;
                        rounds_left <= rounds_left - 8'd1;
                        div         <= '0;
                        tcnt        <= '0;
                    end else begin
                        mole <= mole & ~hit;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        div  <= '0;
                        tcnt <= '0;
                        if (rounds_left != 8'h00) begin
                            state <= SHOW;
                            mole  <= lfsr;
                            lfsr  <= lfsr_step(lfsr);
                        end else begin
                            state <= DONE;
                            mole  <= 8'hFF;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl against a cycle-count game model.
// Two instances: a 2-round game and a 255-round game for score saturation.
module tb_mole_round_ctrl;

    localparam int TD  = 2;
    localparam int ST  = 3;
    localparam int GT  = 1;
    localparam int GR  = 2;
    localparam int GRB = 255;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [7:0] keypad = 8'h00;
    logic [7:0] mole, score, rounds_left;
    logic       busy, game_over;

    logic       RESET_b = 1'b1;
    logic       START_b = 1'b0;
    logic [7:0] keypad_b = 8'h00;
    logic [7:0] mole_b, score_b, rounds_left_b;
    logic       busy_b, game_over_b;

    int vecs = 0;
    int errs = 0;
    bit b_done = 1'b0;

    always #5 CLK = ~CLK;

    mole_round_ctrl #(.TICK_DIV(TD), .SHOW_TICKS(ST), .GAP_TICKS(GT), .GAME_ROUNDS(GR)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .keypad(keypad),
        .mole(mole), .score(score), .rounds_left(rounds_left),
        .busy(busy), .game_over(game_over)
    );

    mole_round_ctrl #(.TICK_DIV(TD), .SHOW_TICKS(ST), .GAP_TICKS(GT), .GAME_ROUNDS(GRB)) dut_b (
        .CLK(CLK), .RESET(RESET_b), .START(START_b), .keypad(keypad_b),
        .mole(mole_b), .score(score_b), .rounds_left(rounds_left_b),
        .busy(busy_b), .game_over(game_over_b)
    );

    // Model: phase plus cycles elapsed since entering it.
    localparam logic [1:0] P_I = 2'd0;
    localparam logic [1:0] P_S = 2'd1;
    localparam logic [1:0] P_G = 2'd2;
    localparam logic [1:0] P_D = 2'd3;

    typedef struct packed {
        logic [1:0]  ph;
        logic [31:0] el;
        logic [7:0]  mole;
        logic [7:0]  score;
        logic [7:0]  rounds;
        logic [7:0]  lfsr;
        logic [7:0]  kpq;
    } m_t;

    function automatic logic [7:0] lstep(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    function automatic m_t mreset();
        m_t m;
        m = '0;
        m.lfsr = 8'hA5;
        return m;
    endfunction

    function automatic m_t mstep(input m_t m, input logic st,
                                 input logic [7:0] kp, input logic [7:0] nr);
        m_t n;
        logic [7:0] h;
        int s;
        n = m;
        h = kp & ~m.kpq & m.mole;
        n.kpq = kp;
        case (m.ph)
            P_I, P_D: begin
                if (st) begin
                    n.ph = P_S;
                    n.el = 0;
                    n.score = 8'h00;
                    n.rounds = nr;
                    n.mole = 8'hA5;
                    n.lfsr = lstep(8'hA5);
                end
            end
            P_S: begin
                s = int'(m.score) + $countones(h);
                n.score = (s > 255) ? 8'hFF : 8'(s);
                if (m.mole == 8'h00 || m.el == 32'(ST * TD - 1)) begin
                    n.ph = P_G;
                    n.el = 0;
                    n.mole = 8'h00;
                    n.rounds = m.rounds - 8'd1;
                end else begin
                    n.el = m.el + 1;
                    n.mole = m.mole & ~h;
                end
            end
            default: begin
                if (m.el == 32'(GT * TD - 1)) begin
                    n.el = 0;
                    if (m.rounds != 8'h00) begin
                        n.ph = P_S;
                        n.mole = m.lfsr;
                        n.lfsr = lstep(m.lfsr);
                    end else begin
                        n.ph = P_D;
                        n.mole = 8'hFF;
                    end
                end else begin
                    n.el = m.el + 1;
                end
            end
        endcase
        return n;
    endfunction

    m_t ma, mb;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) ma <= mreset();
        else       ma <= mstep(ma, START, keypad, 8'(GR));
    end

    always @(posedge CLK or posedge RESET_b) begin
        if (RESET_b) mb <= mreset();
        else         mb <= mstep(mb, START_b, keypad_b, 8'(GRB));
    end

    task automatic cmp(input string nm, input m_t m, input logic [7:0] mo,
                       input logic [7:0] sc, input logic [7:0] rl,
                       input logic bz, input logic go);
        logic ebz, ego;
        ebz = (m.ph == P_S) || (m.ph == P_G);
        ego = (m.ph == P_D);
        vecs++;
        if ({mo, sc, rl, bz, go} !== {m.mole, m.score, m.rounds, ebz, ego}) begin
            errs++;
            $display("FAIL %s model t=%0t got/exp mole=%h/%h score=%0d/%0d rounds=%0d/%0d busy=%b/%b over=%b/%b",
                     nm, $time, mo, m.mole, sc, m.score, rl, m.rounds, bz, ebz, go, ego);
        end
    endtask

    always @(negedge CLK) begin
        cmp("A", ma, mole, score, rounds_left, busy, game_over);
        cmp("B", mb, mole_b, score_b, rounds_left_b, busy_b, game_over_b);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic [7:0] kp);
        START = st;
        keypad = kp;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("rst_mole", mole, 8'h00);
        chk("rst_score", score, 8'h00);
        chk("rst_rounds", rounds_left, 8'h00);
        chk("rst_flags", {6'd0, busy, game_over}, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("idle_hold", {6'd0, busy, game_over}, 8'h00);

        step(1'b1, 8'h00);
        chk("start_mole", mole, 8'hA5);
        chk("start_busy", {7'd0, busy}, 8'h01);
        chk("start_rounds", rounds_left, 8'h02);
        chk("start_score", score, 8'h00);
        step(1'b0, 8'h81);
        chk("hit81_score", score, 8'h02);
        chk("hit81_mole", mole, 8'h24);
        step(1'b0, 8'h81);
        step(1'b0, 8'h81);
        chk("held_score", score, 8'h02);
        step(1'b0, 8'h24);
        chk("clear_mole", mole, 8'h00);
        chk("clear_score", score, 8'h04);
        chk("clear_rounds", rounds_left, 8'h02);
        step(1'b0, 8'h00);
        chk("gap_rounds", rounds_left, 8'h01);
        chk("gap_busy", {7'd0, busy}, 8'h01);
        step(1'b0, 8'h00);
        chk("gap2_mole", mole, 8'h00);
        step(1'b0, 8'h00);
        chk("r2_mole", mole, 8'h4A);
        repeat (5) step(1'b0, 8'h00);
        chk("r2_last_mole", mole, 8'h4A);
        step(1'b0, 8'h00);
        chk("r2_gap_mole", mole, 8'h00);
        chk("r2_gap_rounds", rounds_left, 8'h00);
        step(1'b0, 8'h00);
        chk("r2_gap2_busy", {7'd0, busy}, 8'h01);
        step(1'b0, 8'h00);
        chk("done_flags", {6'd0, busy, game_over}, 8'h01);
        chk("done_mole", mole, 8'hFF);
        chk("done_score", score, 8'h04);

        step(1'b1, 8'h00);
        step(1'b0, 8'h81);
        repeat (4) step(1'b1, 8'h81);
        chk("hold5_score", score, 8'h02);
        chk("busy_start_ign", rounds_left, 8'h02);
        step(1'b1, 8'h81);
        chk("hold_exit_score", score, 8'h02);
        chk("hold_exit_rounds", rounds_left, 8'h01);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        chk("mid_show_busy", {7'd0, busy}, 8'h01);
        #2 RESET = 1'b1;
        #1;
        chk("arst_mole", mole, 8'h00);
        chk("arst_score", score, 8'h00);
        chk("arst_rounds", rounds_left, 8'h00);
        chk("arst_flags", {6'd0, busy, game_over}, 8'h00);
        #2 RESET = 1'b0;
        step(1'b1, 8'h00);
        chk("restart_mole", mole, 8'hA5);

        for (int i = 0; i < 1500; i++) begin
            RESET = ($urandom_range(0, 399) == 0);
            step($urandom_range(0, 15) == 0, 8'($urandom & $urandom));
        end
        RESET = 1'b0;

        for (int i = 0; i < 8000 && !b_done; i++) @(posedge CLK);
        if (!b_done) begin
            vecs++;
            errs++;
            $display("FAIL b_timeout: got not-done want done");
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RESET_b = 1'b0;
        START_b = 1'b1;
        @(posedge CLK);
        #1 START_b = 1'b0;
        for (int i = 0; i < 6000 && !game_over_b; i++) begin
            keypad_b = ~keypad_b;
            @(posedge CLK);
            #1;
        end
        chk("b_over", {7'd0, game_over_b}, 8'h01);
        chk("b_sat", score_b, 8'hFF);
        chk("b_rounds", rounds_left_b, 8'h00);
        b_done = 1'b1;
    end

endmodule
